// File: rtl/mem_loader_pkg.sv
// Purpose: shared types and defaults for the boot-time program loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: FSM state encoding, default WORD_COUNT / BASE_ADDR.
package mem_loader_pkg;

  localparam int          DEFAULT_WORD_COUNT = 256;
  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0000_0000;

  // Fixed encodings keep state values stable across builds; CKSUM and
  // ERROR are only reachable when MEM_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_CKSUM = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Purpose: packs four accepted bytes little-endian into one 32-bit word.
// Latency: word is visible combinationally on the transfer of byte 3.
// Backpressure: none; the caller qualifies take with its own handshake.
// Ports: clk, rst_n (async active-low), clr (sync restart), take (byte
//   transfer), din (byte), word (packed word incl. byte in flight),
//   last (take of byte index 3).
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0]  idx;
  logic [31:0] pack_q;

  // Merging the byte in flight lets the checksum compare happen on the
  // same edge that accepts the final byte.
  always_comb begin
    word = pack_q;
    if (take) begin
      word[8*idx +: 8] = din;
    end
  end

  assign last = take && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= 2'd0;
      pack_q <= 32'd0;
    end else if (clr) begin
      idx    <= 2'd0;
      pack_q <= 32'd0;
    end else if (take) begin
      idx    <= idx + 2'd1;
      pack_q <= word;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Purpose: loads a byte stream into memory words, then hands the port to the CPU.
// Latency: write issued the cycle after byte 3 of a word; min 5 cycles/word.
// Backpressure: o_byte_ready high only in RECV/CKSUM; other bytes stay pending.
// Ports: byte stream (i_byte_valid/i_byte/o_byte_ready), CPU side (i_cpu_*,
//   o_cpu_rdata, o_cpu_rst_n), memory side (o_mem_*, i_mem_rdata), status
//   (o_busy, o_done, o_error). Optional MEM_LOADER_CHECKSUM_EN adds a
//   trailing 32-bit checksum word and an ERROR state.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int          WORD_COUNT = DEFAULT_WORD_COUNT,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  input  logic [31:0] i_cpu_addr,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_cpu_rst_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int            IW       = $clog2(WORD_COUNT) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_COUNT - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] word_idx;
  logic          take, start_go, word_last;
  logic [31:0]   word;
  logic          last_word;

  assign o_byte_ready = (state == ST_RECV) || (state == ST_CKSUM);
  assign take         = i_byte_valid && o_byte_ready;
  assign start_go     = i_start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                    (state == ST_ERROR));
  assign last_word    = (word_idx == LAST_IDX);

  byte_packer u_packer (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (start_go),
    .take  (take),
    .din   (i_byte),
    .word  (word),
    .last  (word_last)
  );

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] acc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                acc <= 32'd0;
    else if (start_go)           acc <= 32'd0;
    else if (state == ST_WRITE)  acc <= acc + word;
  end

  assign o_error = (state == ST_ERROR);
`else
  assign o_error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_go) state_nxt = ST_RECV;
      ST_RECV:  if (word_last) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (last_word) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          state_nxt = ST_CKSUM;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_RECV;
        end
      end
      ST_DONE:  if (start_go) state_nxt = ST_RECV;
`ifdef MEM_LOADER_CHECKSUM_EN
      ST_CKSUM: if (word_last) state_nxt = (word == acc) ? ST_DONE : ST_ERROR;
      ST_ERROR: if (start_go) state_nxt = ST_RECV;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if (start_go)
        word_idx <= '0;
      else if ((state == ST_WRITE) && !last_word)
        word_idx <= word_idx + 1'b1;
    end
  end

  // In DONE the memory port is a transparent pass-through for the CPU.
  always_comb begin
    o_mem_addr  = BASE_ADDR + (32'(word_idx) << 2);
    o_mem_we    = 1'b0;
    o_mem_wdata = 32'd0;
    if (state == ST_WRITE) begin
      o_mem_we    = 1'b1;
      o_mem_wdata = word;
    end else if (state == ST_DONE) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_we    = i_cpu_we;
      o_mem_wdata = i_cpu_wdata;
    end
  end

  assign o_cpu_rdata = i_mem_rdata;
  assign o_cpu_rst_n = (state == ST_DONE);
  assign o_done      = (state == ST_DONE);
  assign o_busy      = (state == ST_RECV) || (state == ST_WRITE) ||
                       (state == ST_CKSUM);

endmodule
